// File: rtl/writeback_unit.sv
// writeback_unit
//   Writeback and hazard stage in front of register_bank. It arbitrates ALU and
//   LSU results into a registered bank write port. It keeps a 32-entry busy
//   scoreboard of pending long-latency destinations and raises an issue stall
//   on hazards against them.
//
//   Optional feature: define WB_FORWARD_EN to bypass the in-flight write value
//   onto the operand read path. When it is undefined, a same-cycle RAW against
//   the write port stalls issue for one cycle instead.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   iss_valid/iss_long/iss_rd/rs1/rs2   issuing instruction
//   iss_stall                           combinational issue hold
//   alu_valid/alu_rd/alu_val            ALU result (always accepted)
//   lsu_valid/lsu_ready/lsu_rd/lsu_val  LSU result handshake
//   reg_we/rd/rd_val                    registered bank write port
//   rs1/rs2_bank_val                    raw bank read data
//   rs1/rs2_val                         operands delivered to execute
module writeback_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic            iss_long,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            iss_stall,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_val,
    output logic            reg_we,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rd_val,
    input  logic [XLEN-1:0] rs1_bank_val,
    input  logic [XLEN-1:0] rs2_bank_val,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val
);

    logic            buf_full;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_val;
    logic [31:0]     busy;

    logic            lsu_acc;
    logic            sel_valid;
    logic            sel_lsu;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_val;
    logic            buf_load;
    logic            buf_drain;
    logic            busy_set;
    logic [31:0]     busy_nxt;
    logic            hazard_busy;
    logic            hazard_wb;

    // Ready comes straight from the buffer flag register, so the cycle that
    // drains the buffer still reports not-ready.
    assign lsu_ready = !buf_full;
    assign lsu_acc   = lsu_valid & !buf_full;

    // Source select: ALU, then buffered LSU entry, then a direct LSU accept.
    always_comb begin
        sel_valid = 1'b0;
        sel_lsu   = 1'b0;
        sel_rd    = '0;
        sel_val   = '0;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_val   = alu_val;
            buf_load  = lsu_acc;
        end else if (buf_full) begin
            sel_valid = 1'b1;
            sel_lsu   = 1'b1;
            sel_rd    = buf_rd;
            sel_val   = buf_val;
            buf_drain = 1'b1;
        end else if (lsu_acc) begin
            sel_valid = 1'b1;
            sel_lsu   = 1'b1;
            sel_rd    = lsu_rd;
            sel_val   = lsu_val;
        end
    end

    assign hazard_busy = busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd];

`ifdef WB_FORWARD_EN
    assign hazard_wb = 1'b0;
    assign rs1_val = (reg_we && rd == iss_rs1 && iss_rs1 != 5'd0) ? rd_val : rs1_bank_val;
    assign rs2_val = (reg_we && rd == iss_rs2 && iss_rs2 != 5'd0) ? rd_val : rs2_bank_val;
`else
    assign hazard_wb = reg_we & (rd != 5'd0) & ((rd == iss_rs1) | (rd == iss_rs2));
    assign rs1_val   = rs1_bank_val;
    assign rs2_val   = rs2_bank_val;
`endif

    assign iss_stall = iss_valid & (hazard_busy | hazard_wb);
    assign busy_set  = iss_valid & iss_long & !iss_stall & (iss_rd != 5'd0);

    // Clear is applied before set so a same-index set in the same cycle wins.
    always_comb begin
        busy_nxt = busy;
        if (sel_lsu) busy_nxt[sel_rd] = 1'b0;
        if (busy_set) busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_we   <= 1'b0;
            rd       <= '0;
            rd_val   <= '0;
            buf_full <= 1'b0;
            buf_rd   <= '0;
            buf_val  <= '0;
            busy     <= '0;
        end else begin
            // x0 writes still load rd/rd_val but never enable the bank.
            reg_we <= sel_valid & (sel_rd != 5'd0);
            if (sel_valid) begin
                rd     <= sel_rd;
                rd_val <= sel_val;
            end
            if (buf_load) begin
                buf_full <= 1'b1;
                buf_rd   <= lsu_rd;
                buf_val  <= lsu_val;
            end else if (buf_drain) begin
                buf_full <= 1'b0;
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid = 0, iss_long = 0;
    logic [4:0]  iss_rd = 0, iss_rs1 = 0, iss_rs2 = 0;
    logic        iss_stall;
    logic        alu_valid = 0;
    logic [4:0]  alu_rd = 0;
    logic [31:0] alu_val = 0;
    logic        lsu_valid = 0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = 0;
    logic [31:0] lsu_val = 0;
    logic        reg_we;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic [31:0] rs1_bank_val = 0, rs2_bank_val = 0;
    logic [31:0] rs1_val, rs2_val;

    int checks = 0;
    int errors = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    writeback_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_val(lsu_val),
        .reg_we(reg_we), .rd(rd), .rd_val(rd_val),
        .rs1_bank_val(rs1_bank_val), .rs2_bank_val(rs2_bank_val),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    always #5 clk = ~clk;

    // Reference model: the last written port value, a queue of accepted but
    // not yet written LSU results, and a set of pending long destinations.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;
    wr_t         m_pend[$];
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_val;
    bit          m_busy[32];

    task automatic model_reset();
        m_we = 0; m_rd = 0; m_val = 0;
        m_pend.delete();
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    function automatic bit exp_stall();
        bit s;
        if (!iss_valid) return 0;
        s = m_busy[iss_rs1] || m_busy[iss_rs2] || m_busy[iss_rd];
        if (!FWD && m_we && m_rd != 0 && (m_rd == iss_rs1 || m_rd == iss_rs2)) s = 1;
        return s;
    endfunction

    function automatic logic [31:0] exp_op(logic [4:0] rs, logic [31:0] bank);
        if (FWD && m_we && m_rd == rs && rs != 0) return m_val;
        return bank;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_pend.size() == 0});
        check("reg_we", {31'd0, reg_we}, {31'd0, m_we});
        check("rd", {27'd0, rd}, {27'd0, m_rd});
        check("rd_val", rd_val, m_val);
        check("iss_stall", {31'd0, iss_stall}, {31'd0, exp_stall()});
        check("rs1_val", rs1_val, exp_op(iss_rs1, rs1_bank_val));
        check("rs2_val", rs2_val, exp_op(iss_rs2, rs2_bank_val));
    endtask

    task automatic model_advance();
        bit   acc, stall, wr, from_lsu;
        wr_t  w;
        acc   = lsu_valid && m_pend.size() == 0;
        stall = exp_stall();
        wr = 0; from_lsu = 0;
        if (alu_valid) begin
            wr = 1; w.rd = alu_rd; w.val = alu_val;
            if (acc) m_pend.push_back('{lsu_rd, lsu_val});
        end else if (m_pend.size() != 0) begin
            wr = 1; from_lsu = 1; w = m_pend.pop_front();
        end else if (acc) begin
            wr = 1; from_lsu = 1; w.rd = lsu_rd; w.val = lsu_val;
        end
        if (wr) begin
            m_we = (w.rd != 0); m_rd = w.rd; m_val = w.val;
            if (from_lsu) m_busy[w.rd] = 0;
        end else begin
            m_we = 0;
        end
        if (iss_valid && iss_long && !stall && iss_rd != 0) m_busy[iss_rd] = 1;
        m_busy[0] = 0;
    endtask

    // Inputs are already applied; check mid-cycle, advance model, cross edge.
    task automatic step();
        #2;
        compare_all();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_val = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_val = 0;
    endtask

    initial begin
        model_reset();
        idle();
        rs1_bank_val = 32'h5555_0001;
        rs2_bank_val = 32'h6666_0002;
        #12;
        check("rst_reg_we", {31'd0, reg_we}, 32'd0);
        check("rst_rd_val", rd_val, 32'd0);
        check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        rst_n = 1;
        @(posedge clk); #1;
        step();

        // ALU write latency
        alu_valid = 1; alu_rd = 5; alu_val = 32'h1234;
        step();
        idle();
        check("alu_we_n1", {31'd0, reg_we}, 32'd1);
        check("alu_rd_n1", {27'd0, rd}, 32'd5);
        check("alu_val_n1", rd_val, 32'h1234);
        step();
        check("alu_we_n2", {31'd0, reg_we}, 32'd0);

        // ALU/LSU collision
        alu_valid = 1; alu_rd = 2; alu_val = 32'h2222;
        lsu_valid = 1; lsu_rd = 7; lsu_val = 32'hAAAA;
        step();
        idle();
        check("col_alu_rd", {27'd0, rd}, 32'd2);
        check("col_ready_low", {31'd0, lsu_ready}, 32'd0);
        step();
        check("col_lsu_we", {31'd0, reg_we}, 32'd1);
        check("col_lsu_rd", {27'd0, rd}, 32'd7);
        check("col_lsu_val", rd_val, 32'hAAAA);

        // Scoreboard hazard on x9
        iss_valid = 1; iss_long = 1; iss_rd = 9;
        step();
        idle();
        iss_valid = 1; iss_rs1 = 9; iss_rd = 10;
        #1;
        check("sb_stall_busy", {31'd0, iss_stall}, 32'd1);
        lsu_valid = 1; lsu_rd = 9; lsu_val = 32'hBEEF;
        step();
        lsu_valid = 0;
        #1;
        check("sb_stall_wb", {31'd0, iss_stall}, FWD ? 32'd0 : 32'd1);
        if (FWD) check("sb_fwd_val", rs1_val, 32'hBEEF);
        else     check("sb_bank_val", rs1_val, 32'h5555_0001);
        step();
        #1;
        check("sb_stall_gone", {31'd0, iss_stall}, 32'd0);
        idle();
        step();

        // x0 handling
        lsu_valid = 1; lsu_rd = 0; lsu_val = 32'h77;
        step();
        idle();
        check("x0_we", {31'd0, reg_we}, 32'd0);
        iss_valid = 1; iss_long = 1; iss_rd = 0;
        step();
        iss_long = 0;
        #1;
        check("x0_no_stall", {31'd0, iss_stall}, 32'd0);
        step();
        idle();

        // Set wins over clear on x4
        iss_valid = 1; iss_long = 1; iss_rd = 4;
        lsu_valid = 1; lsu_rd = 4; lsu_val = 32'h4444;
        step();
        idle();
        iss_valid = 1; iss_rs1 = 4; iss_rd = 11;
        #1;
        check("setwin_stall", {31'd0, iss_stall}, 32'd1);
        step();
        idle();
        lsu_valid = 1; lsu_rd = 4; lsu_val = 32'h4445;
        step();
        idle();
        step();
        step();

        // Async reset with buffer full and x3 busy
        iss_valid = 1; iss_long = 1; iss_rd = 3;
        step();
        idle();
        alu_valid = 1; alu_rd = 1; alu_val = 32'h11;
        lsu_valid = 1; lsu_rd = 8; lsu_val = 32'h88;
        step();
        lsu_valid = 0;
        #1;
        check("ar_pre_ready", {31'd0, lsu_ready}, 32'd0);
        #1;
        rst_n = 0;
        idle();
        iss_valid = 1; iss_rs1 = 3; iss_rd = 12;
        #1;
        check("ar_ready", {31'd0, lsu_ready}, 32'd1);
        check("ar_no_stall", {31'd0, iss_stall}, 32'd0);
        check("ar_we", {31'd0, reg_we}, 32'd0);
        model_reset();
        #2;
        rst_n = 1;
        idle();
        @(posedge clk); #1;
        step();
        check("ar_no_pending", {31'd0, reg_we}, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd = 0;
            for (int t = 0; t < 32; t++) begin
                logic [4:0] r;
                r = 5'($urandom_range(0, 15));
                if (!m_busy[r]) begin alu_rd = r; break; end
            end
            alu_val   = $urandom;
            lsu_valid = ($urandom_range(0, 9) < 4);
            lsu_rd    = 5'($urandom_range(0, 15));
            lsu_val   = $urandom;
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_long  = $urandom_range(0, 1);
            iss_rd    = 5'($urandom_range(0, 15));
            iss_rs1   = 5'($urandom_range(0, 15));
            iss_rs2   = 5'($urandom_range(0, 15));
            rs1_bank_val = $urandom;
            rs2_bank_val = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback and hazard stage placed in front of `register_bank`. It accepts results from the single-cycle ALU path and from the long-latency load/store path through a valid/ready handshake. It arbitrates between them and drives the bank write port (`reg_we`, `rd`, `rd_val`) from registered outputs. It also keeps a 32-entry busy scoreboard and raises an issue stall on hazards against pending long-latency destinations. Optionally, it bypasses the in-flight write value onto the operand read path.

## Interface
Parameters:
- `XLEN`, 32, data width of results and operands.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: an instruction is presented for issue this cycle.
- `iss_long` in 1: the issuing instruction produces its result via the LSU path.
- `iss_rd`, `iss_rs1`, `iss_rs2` in 5: destination and source register addresses of the issuing instruction.
- `iss_stall` out 1: combinational; issue must hold this cycle.
- `alu_valid` in 1: ALU result present; always accepted, no ready.
- `alu_rd` in 5, `alu_val` in XLEN: ALU destination and result.
- `lsu_valid` in 1, `lsu_ready` out 1: LSU result handshake.
- `lsu_rd` in 5, `lsu_val` in XLEN: LSU destination and result.
- `reg_we` out 1, `rd` out 5, `rd_val` out XLEN: registered write port to the bank.
- `rs1_bank_val`, `rs2_bank_val` in XLEN: raw bank read data.
- `rs1_val`, `rs2_val` out XLEN: operand values delivered to execute.

## Operation
- Output stage: a register holding `reg_we/rd/rd_val`, loaded every cycle with the selected source. If no source is selected, `reg_we` is loaded with 0.
- Priority, highest first: `alu_valid`, then the buffered LSU entry, then a direct LSU accept.
- LSU buffer: one entry. `lsu_ready = !buf_full`, driven from a register only.
- LSU accept (`lsu_valid & lsu_ready`):
  - With `alu_valid=0` and the buffer empty, the result goes straight to the output stage.
  - Otherwise the result is captured in the buffer.
- The buffer drains on the first cycle with `alu_valid=0`. `lsu_ready` stays 0 during that cycle.
- Writes to x0: the output stage loads `reg_we=0`, with `rd` and `rd_val` still loaded. The scoreboard is untouched.
- Scoreboard `busy[31:0]`:
  - Set: `iss_valid & iss_long & !iss_stall & iss_rd!=0` sets `busy[iss_rd]`.
  - Clear: an LSU result loaded into the output stage clears `busy[lsu_rd]`.
  - A set and a clear of the same index in the same cycle: the set wins.
  - `busy[0]` is always 0.
- Stall: `iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd])`, plus the configuration term below. Register index 0 never stalls.
- ALU results are never stalled. The issue logic guarantees that an ALU `rd` is never busy.

## Timing
- Reset values:
  - `reg_we=0`, `rd=0`, `rd_val=0`.
  - Buffer empty, so `lsu_ready=1`.
  - `busy=0`.
  - `iss_stall` follows its combinational equation, so it is 0 after reset.
- Reset asserted mid-operation discards any buffered LSU result and all busy bits immediately (asynchronous).
- ALU result in cycle n: `reg_we` is high in cycle n+1. The bank holds the value from cycle n+2.
- LSU accept in cycle n with no conflict: writeback in n+1.
  - If buffered, writeback occurs one cycle after the first ALU-idle cycle.
  - Worst case is unbounded while `alu_valid` stays high.
- The busy bit clears at the same edge that raises `reg_we` for that LSU result.

## Configuration
- `WB_FORWARD_EN` defined:
  - `rsN_val = rd_val` when `reg_we & rd==iss_rsN & iss_rsN!=0`; otherwise `rsN_val = rsN_bank_val`.
  - No extra stall term.
- Undefined:
  - `rsN_val = rsN_bank_val`.
  - `iss_stall` additionally asserts when `iss_valid & reg_we & rd!=0 & (rd==iss_rs1 | rd==iss_rs2)`, which costs one bubble per same-cycle RAW.

## Test plan
- Reset check: assert reset, then release → outputs 0, `lsu_ready=1`. Then `alu_valid=1, alu_rd=5, alu_val=0x1234` at cycle n → `reg_we=1, rd=5, rd_val=0x1234` in n+1, and `reg_we=0` in n+2.
- Collision: `alu_valid` and `lsu_valid` (rd=7, 0xAAAA) in the same cycle → ALU written in n+1, `lsu_ready=0` in n+1. With ALU idle in n+1, x7 is written with 0xAAAA in n+2.
- Scoreboard: long issue with rd=9, then an issue reading rs1=9 → `iss_stall=1` until the LSU result for x9 reaches `reg_we`. With `WB_FORWARD_EN` the stall drops that same cycle and `rs1_val=` the LSU value. Without it, the stall lasts one extra cycle.
- x0: an LSU result to rd=0 → `reg_we=0`. An issue with rd=0 and `iss_long=1` → no busy bit set, no stall.
- Set-wins: a new long issue to x4 in the same cycle the old x4 result clears → `busy[4]` remains 1.
- Async reset with the buffer full and `busy[3]=1` → `lsu_ready=1` and `busy=0` immediately, with no pending write afterwards.
